// File: rtl/tb_pkg.sv
// Shared types and constants for the testbench sink memory and its stall LFSR.
package tb_pkg;

  typedef enum logic [1:0] {WR_IDLE, WR_RUN, WR_DONE} tb_wr_state_t;

  localparam int          LfsrWidth = 16;
  // Taps 16,14,13,11 (1-based) expressed as a bit mask over lfsr[15:0]
  localparam logic [15:0] LfsrTaps  = 16'hB400;

endpackage

// File: rtl/tb_lfsr.sv
// Fibonacci LFSR used to throttle stream handshakes; advances only while enabled.
module tb_lfsr
  import tb_pkg::*;
#(
  parameter int               Width = LfsrWidth,
  parameter logic [Width-1:0] Seed  = Width'(16'hACE1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] lfsr_o
);

  logic [Width-1:0] lfsr_q;
  logic             feedback;

  assign feedback = ^(lfsr_q & Width'(LfsrTaps));
  assign lfsr_o   = lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[Width-2:0], feedback};
    end
  end

endmodule

// File: rtl/tb_wr_memory.sv
// Sink memory capturing the accelerator output stream at auto-incremented addresses,
// with a combinational host read port and optional pseudo-random ready throttling.
module tb_wr_memory
  import tb_pkg::*;
#(
  parameter int          DataWidth = 32,
  parameter int          AddrWidth = 32,
  parameter int          MemDepth  = 1024,
  parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [AddrWidth-1:0] target_cnt_i,
  input  logic                 stall_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o,
  input  logic [DataWidth-1:0] acc_data_i,
  input  logic                 acc_valid_i,
  output logic                 acc_ready_o,
  output logic [AddrWidth-1:0] wr_count_o,
  output logic                 done_o,
  output logic                 full_o
);

  localparam int                   IdxW   = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam logic [AddrWidth-1:0] DepthA = AddrWidth'(MemDepth);

  tb_wr_state_t         state_q, state_d;
  logic [AddrWidth-1:0] wr_count_q;
  logic [AddrWidth-1:0] wr_next;
  logic [DataWidth-1:0] mem_q [MemDepth];
  logic [15:0]          lfsr;
  logic                 lfsr_en;
  logic                 lfsr_unused;
  logic                 full;
  logic                 ready;
  logic                 accept;
  logic                 start;

  assign lfsr_en = (state_q == WR_RUN);

  tb_lfsr #(
    .Width(16),
    .Seed (LfsrSeed)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (lfsr_en),
    .lfsr_o(lfsr)
  );

  // Only bit 0 gates ready; the upper bits are state internal to the LFSR
  assign lfsr_unused = ^lfsr[15:1];

  assign full    = (wr_count_q == DepthA);
  assign ready   = (state_q == WR_RUN) && en_i && !full && !(stall_en_i && lfsr[0]);
  assign accept  = acc_valid_i && ready;
  assign wr_next = wr_count_q + AddrWidth'(1);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (en_i) begin
          state_d = WR_RUN;
          start   = 1'b1;
        end
      end
      WR_RUN: begin
        // A target already passed never matches wr_next again, so it cannot fire DONE
        if (!en_i) begin
          state_d = WR_IDLE;
        end else if (accept && (target_cnt_i != '0) && (wr_next == target_cnt_i)) begin
          state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        if (!en_i) begin
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WR_IDLE;
      wr_count_q <= '0;
      for (int i = 0; i < MemDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start) begin
        wr_count_q <= '0;
      end else if (accept) begin
        wr_count_q <= wr_next;
      end
      if (accept) begin
        mem_q[wr_count_q[IdxW-1:0]] <= acc_data_i;
      end
    end
  end

  assign rd_data_o   = (rd_addr_i < DepthA) ? mem_q[rd_addr_i[IdxW-1:0]] : '0;
  assign acc_ready_o = ready;
  assign wr_count_o  = wr_count_q;
  assign done_o      = (state_q == WR_DONE);
  assign full_o      = full;

endmodule
